// File: rtl/alu_pkg.sv
// Shared ALU definitions: multiplier FSM state encoding and iteration constants.
package alu_pkg;

    localparam int         MUL_WIDTH = 32;
    localparam logic [4:0] MUL_LAST  = 5'd31;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RUN     = 2'b01,
        ST_DONE    = 2'b10,
        ST_ILLEGAL = 2'b11
    } mul_state_e;

endpackage

// File: rtl/mul32_seq_if.sv
// Start/busy/done handshake plus operand and product buses between ALU control and the multiplier.
interface mul32_seq_if;
    import alu_pkg::*;

    logic                     start;
    logic [MUL_WIDTH-1:0]     a;
    logic [MUL_WIDTH-1:0]     b;
    logic                     busy;
    logic                     done;
    logic [2*MUL_WIDTH-1:0]   p;

    modport master (
        output start,
        output a,
        output b,
        input  busy,
        input  done,
        input  p
    );

    modport slave (
        input  start,
        input  a,
        input  b,
        output busy,
        output done,
        output p
    );

endinterface

// File: rtl/mul32_seq_and32.sv
// Fixed-width partial-product gate: B is A when ty is set, otherwise zero.
module AND32 (
    input  logic [31:0] A,
    input  logic        ty,
    output logic [31:0] B
);

    assign B = A & {32{ty}};

endmodule

// File: rtl/mul32_seq.sv
// Sequential 32x32 unsigned shift-add multiplier; one partial product per cycle, 64-bit result after 32 steps.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | waiting for start; operands loaded on start
// ST_RUN  | one add/shift step per cycle, count 0..31
// ST_DONE | one-cycle done pulse; start here reloads for back-to-back
module mul32_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic        clk,
    input  logic        rst,
    mul32_seq_if.slave  bus
);

    // The partial-product gate is hard-wired to 32 bits, so no other width can work.
    if (WIDTH != MUL_WIDTH || CNT_W != 5) begin : g_bad_param
        $error("mul32_seq: only WIDTH=32, CNT_W=5 are supported");
    end

    mul_state_e           state;
    mul_state_e           state_nxt;

    logic [WIDTH-1:0]     a_reg;
    logic [WIDTH-1:0]     hi;
    logic [WIDTH-1:0]     lo;
    logic [CNT_W-1:0]     count;
    logic [WIDTH-1:0]     pp;
    logic [WIDTH:0]       sum;
    logic                 load;

    AND32 u_and32 (
        .A  (a_reg),
        .ty (lo[0]),
        .B  (pp)
    );

    // Carry out of the add is kept in sum[WIDTH] and shifts down into hi.
    assign sum  = {1'b0, hi} + {1'b0, pp};
    assign load = ((state == ST_IDLE) || (state == ST_DONE)) && bus.start;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (count == MUL_LAST) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = bus.start ? ST_RUN : ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        bus.busy = (state == ST_RUN);
        bus.done = (state == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg <= '0;
            hi    <= '0;
            lo    <= '0;
            count <= '0;
            bus.p <= '0;
        end else if (load) begin
            a_reg <= bus.a;
            hi    <= '0;
            lo    <= bus.b;
            count <= '0;
        end else if (state == ST_RUN) begin
            hi    <= sum[WIDTH:1];
            lo    <= {sum[0], lo[WIDTH-1:1]};
            count <= count + 1'b1;
            if (count == MUL_LAST) begin
                bus.p <= {sum, lo[WIDTH-1:1]};
            end
        end
    end

endmodule

// File: tb/tb_mul32_seq.sv
// Self-checking bench for mul32_seq: directed scenarios plus randomized operands against a plain-arithmetic model.
module tb_mul32_seq;
    import alu_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    logic [63:0] prev_p;
    logic [63:0] exp_p;

    mul32_seq_if bus_if ();

    mul32_seq #(
        .WIDTH (32),
        .CNT_W (5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
        logic [63:0] xx;
        logic [63:0] yy;
        xx = {32'h0, x};
        yy = {32'h0, y};
        return xx * yy;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus_if.start = 1'($urandom);
            bus_if.a     = $urandom;
            bus_if.b     = $urandom;
            step();
            checks++;
            if ({bus_if.busy, bus_if.done} !== 2'b00) begin
                errors++;
                $display("FAIL reset_flags cycle %0d: busy/done=%b expected 00", i, {bus_if.busy, bus_if.done});
            end
            checks++;
            if (bus_if.p !== 64'h0) begin
                errors++;
                $display("FAIL reset_p cycle %0d: got %h expected 0", i, bus_if.p);
            end
        end
        rst          = 1'b0;
        bus_if.start = 1'b0;
        step();
        checks++;
        if ({bus_if.busy, bus_if.done} !== 2'b00 || bus_if.p !== 64'h0) begin
            errors++;
            $display("FAIL reset_release: busy/done=%b p=%h expected 00 and 0", {bus_if.busy, bus_if.done}, bus_if.p);
        end
        prev_p = 64'h0;
    endtask

    task automatic test_basic();
        bus_if.start = 1'b1;
        bus_if.a     = 32'd3;
        bus_if.b     = 32'd5;
        step();
        bus_if.start = 1'b0;
        bus_if.a     = $urandom;
        bus_if.b     = $urandom;
        for (int i = 0; i < 32; i++) begin
            checks++;
            if ({bus_if.busy, bus_if.done} !== 2'b10 || bus_if.p !== prev_p) begin
                errors++;
                $display("FAIL basic_run cycle %0d: busy/done=%b p=%h expected 10 and %h", i, {bus_if.busy, bus_if.done}, bus_if.p, prev_p);
            end
            step();
        end
        checks++;
        if ({bus_if.busy, bus_if.done} !== 2'b01) begin
            errors++;
            $display("FAIL basic_done: busy/done=%b expected 01", {bus_if.busy, bus_if.done});
        end
        checks++;
        if (bus_if.p !== 64'h000000000000000F) begin
            errors++;
            $display("FAIL basic_p: got %h expected %h", bus_if.p, 64'h000000000000000F);
        end
        step();
        checks++;
        if ({bus_if.busy, bus_if.done} !== 2'b00 || bus_if.p !== 64'h000000000000000F) begin
            errors++;
            $display("FAIL basic_after: busy/done=%b p=%h expected 00 and f", {bus_if.busy, bus_if.done}, bus_if.p);
        end
        prev_p = 64'h000000000000000F;
    endtask

    task automatic test_carry();
        exp_p        = ref_mul(32'hFFFFFFFF, 32'hFFFFFFFF);
        bus_if.start = 1'b1;
        bus_if.a     = 32'hFFFFFFFF;
        bus_if.b     = 32'hFFFFFFFF;
        step();
        bus_if.start = 1'b0;
        bus_if.a     = 32'h0;
        bus_if.b     = 32'h0;
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (bus_if.busy !== 1'b1 || bus_if.p !== prev_p) begin
                errors++;
                $display("FAIL carry_run cycle %0d: busy=%b p=%h expected 1 and %h", i, bus_if.busy, bus_if.p, prev_p);
            end
            step();
        end
        checks++;
        if (bus_if.done !== 1'b1 || bus_if.p !== 64'hFFFFFFFE00000001 || bus_if.p !== exp_p) begin
            errors++;
            $display("FAIL carry_p: done=%b p=%h expected 1 and %h", bus_if.done, bus_if.p, 64'hFFFFFFFE00000001);
        end
        step();
        prev_p = exp_p;
    endtask

    task automatic test_back_to_back();
        bus_if.start = 1'b1;
        bus_if.a     = 32'h12345678;
        bus_if.b     = 32'h0;
        step();
        bus_if.b = 32'h1;
        for (int i = 0; i < 32; i++) begin
            checks++;
            if ({bus_if.busy, bus_if.done} !== 2'b10 || bus_if.p !== prev_p) begin
                errors++;
                $display("FAIL b2b_run1 cycle %0d: busy/done=%b p=%h expected 10 and %h", i, {bus_if.busy, bus_if.done}, bus_if.p, prev_p);
            end
            step();
        end
        checks++;
        if (bus_if.done !== 1'b1 || bus_if.p !== 64'h0) begin
            errors++;
            $display("FAIL b2b_zero: done=%b p=%h expected 1 and 0", bus_if.done, bus_if.p);
        end
        step();
        bus_if.start = 1'b0;
        bus_if.a     = $urandom;
        bus_if.b     = $urandom;
        // 32 busy cycles separate the two done pulses.
        for (int i = 0; i < 32; i++) begin
            checks++;
            if ({bus_if.busy, bus_if.done} !== 2'b10 || bus_if.p !== 64'h0) begin
                errors++;
                $display("FAIL b2b_run2 cycle %0d: busy/done=%b p=%h expected 10 and 0", i, {bus_if.busy, bus_if.done}, bus_if.p);
            end
            step();
        end
        checks++;
        if (bus_if.done !== 1'b1 || bus_if.p !== 64'h0000000012345678) begin
            errors++;
            $display("FAIL b2b_ident: done=%b p=%h expected 1 and %h", bus_if.done, bus_if.p, 64'h0000000012345678);
        end
        step();
        checks++;
        if ({bus_if.busy, bus_if.done} !== 2'b00) begin
            errors++;
            $display("FAIL b2b_idle: busy/done=%b expected 00", {bus_if.busy, bus_if.done});
        end
        prev_p = 64'h0000000012345678;
    endtask

    task automatic test_ignore_busy();
        bus_if.start = 1'b1;
        bus_if.a     = 32'd7;
        bus_if.b     = 32'd6;
        step();
        bus_if.start = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (i == 10) begin
                bus_if.start = 1'b1;
                bus_if.a     = 32'd9;
                bus_if.b     = 32'd9;
            end else if (i == 11) begin
                bus_if.start = 1'b0;
                bus_if.a     = $urandom;
                bus_if.b     = $urandom;
            end
            checks++;
            if ({bus_if.busy, bus_if.done} !== 2'b10 || bus_if.p !== prev_p) begin
                errors++;
                $display("FAIL ignore_run cycle %0d: busy/done=%b p=%h expected 10 and %h", i, {bus_if.busy, bus_if.done}, bus_if.p, prev_p);
            end
            step();
        end
        checks++;
        if (bus_if.done !== 1'b1 || bus_if.p !== 64'd42) begin
            errors++;
            $display("FAIL ignore_p: done=%b p=%h expected 1 and %h", bus_if.done, bus_if.p, 64'd42);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if ({bus_if.busy, bus_if.done} !== 2'b00 || bus_if.p !== 64'd42) begin
                errors++;
                $display("FAIL ignore_single cycle %0d: busy/done=%b p=%h expected 00 and 2a", i, {bus_if.busy, bus_if.done}, bus_if.p);
            end
        end
        prev_p = 64'd42;
    endtask

    task automatic test_abort();
        int done_seen;
        bus_if.start = 1'b1;
        bus_if.a     = $urandom;
        bus_if.b     = $urandom;
        step();
        bus_if.start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({bus_if.busy, bus_if.done} !== 2'b00 || bus_if.p !== 64'h0) begin
            errors++;
            $display("FAIL abort_reset: busy/done=%b p=%h expected 00 and 0", {bus_if.busy, bus_if.done}, bus_if.p);
        end
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (bus_if.done === 1'b1 || bus_if.busy === 1'b1) done_seen++;
        end
        checks++;
        if (done_seen !== 0) begin
            errors++;
            $display("FAIL abort_quiet: %0d active cycles expected 0", done_seen);
        end
        bus_if.start = 1'b1;
        bus_if.a     = 32'd100;
        bus_if.b     = 32'd200;
        step();
        bus_if.start = 1'b0;
        for (int i = 0; i < 32; i++) begin
            step();
        end
        checks++;
        if (bus_if.done !== 1'b1 || bus_if.p !== 64'd20000) begin
            errors++;
            $display("FAIL abort_next: done=%b p=%h expected 1 and %h", bus_if.done, bus_if.p, 64'd20000);
        end
        step();
        prev_p = 64'd20000;
    endtask

    task automatic test_random();
        logic [31:0] na;
        logic [31:0] nb;
        int          lat;
        int          p_moved;
        for (int n = 0; n < 10; n++) begin
            na = $urandom;
            nb = $urandom;
            if (n == 0) na = 32'h0;
            if (n == 1) nb = 32'h0;
            if (n == 2) na = 32'h80000001;
            exp_p = ref_mul(na, nb);
            repeat ($urandom_range(0, 3)) step();
            bus_if.start = 1'b1;
            bus_if.a     = na;
            bus_if.b     = nb;
            step();
            bus_if.start = 1'b0;
            lat          = 0;
            p_moved      = 0;
            while (bus_if.done !== 1'b1 && lat < 40) begin
                bus_if.a = $urandom;
                bus_if.b = $urandom;
                if (bus_if.p !== prev_p) p_moved++;
                step();
                lat++;
            end
            checks++;
            if (lat !== 32 || p_moved !== 0) begin
                errors++;
                $display("FAIL rand_latency op %0d: %0d cycles, p moved %0d times; expected 32 and 0", n, lat, p_moved);
            end
            checks++;
            if (bus_if.p !== exp_p) begin
                errors++;
                $display("FAIL rand_p op %0d: a=%h b=%h got %h expected %h", n, na, nb, bus_if.p, exp_p);
            end
            prev_p = exp_p;
            step();
        end
    endtask

    initial begin
        clk          = 1'b0;
        rst          = 1'b1;
        checks       = 0;
        errors       = 0;
        prev_p       = 64'h0;
        exp_p        = 64'h0;
        bus_if.start = 1'b0;
        bus_if.a     = 32'h0;
        bus_if.b     = 32'h0;

        test_reset();
        test_basic();
        test_carry();
        test_back_to_back();
        test_ignore_busy();
        test_abort();
        test_random();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
